raw10_unpacker: RTL and testbench

- Sits directly downstream of pckthandler. Consumes its stripped 16-bit payload words and frame-active flag.
- Unpacks MIPI CSI-2 RAW10 byte groups into 10-bit pixels, presented 4 per cycle with line/frame markers.
- Feeds the pixel pipeline and frame capture logic.
- No backpressure: input rate of 2 bytes/cycle yields at most 1 group per 2 cycles.

---
 rtl/raw10_unpacker.sv | 151 +++++++++++++++
 tb/tb_raw10_unpacker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw10_unpacker.sv
// raw10_unpacker: unpacks CSI-2 RAW10 5-byte groups from a 16-bit payload
// stream into 4 x 10-bit pixels per group, with frame/line markers.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   din[15:0]      payload word; din[7:0] earlier byte, din[15:8] later byte
//   din_valid      din carries 2 payload bytes
//   fr_active      frame in progress
//   pix[39:0]      {P3,P2,P1,P0}, 10 bits each, held when pix_valid=0
//   pix_valid      one-cycle pulse per group
//   pix_sof        first group of frame (with pix_valid)
//   pix_eol        last group of line (with pix_valid)
//   frame_err      pulse: frame ended with a partial group or partial line
//   row_idx[15:0]  row of the presented group (only with RAW10_ROWCNT_EN)
//
// Optional feature macro: RAW10_ROWCNT_EN (adds the row_idx output).
module raw10_unpacker #(
    parameter int LINE_PIXELS = 3280
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] din,
    input  logic        din_valid,
    input  logic        fr_active,
    output logic [39:0] pix,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
`ifdef RAW10_ROWCNT_EN
    output logic        frame_err,
    output logic [15:0] row_idx
`else
    output logic        frame_err
`endif
);

    localparam int GROUPS = LINE_PIXELS / 4;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

    // Between words at most 4 bytes are ever retained, so 4 entries of
    // storage plus the 2 incoming bytes cover the 6-byte window.
    logic [7:0]    byte_q [4];
    logic [2:0]    cnt;
    logic [GW-1:0] grp_cnt;
    logic          sof_pending;
    logic          fr_d;

    logic [7:0]    ext [6];
    logic [2:0]    cnt_sum;
    logic          grp_done;
    logic [39:0]   grp_pix;
    logic          accept;
    logic          fall;

    assign accept   = din_valid & fr_active;
    assign fall     = fr_d & ~fr_active;
    assign cnt_sum  = cnt + 3'd2;
    assign grp_done = (cnt_sum >= 3'd5);

    // Window of retained bytes followed by the incoming pair, oldest first.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            ext[i] = 8'h00;
            if (3'(i) == cnt)
                ext[i] = din[7:0];
            else if (3'(i) == cnt + 3'd1)
                ext[i] = din[15:8];
        end
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt)
                ext[i] = byte_q[i];
        end
    end

    // Pn = {Bn, B4[2n+1:2n]}
    always_comb begin
        grp_pix = '0;
        for (int n = 0; n < 4; n++)
            grp_pix[10*n +: 10] = {ext[n], ext[4][2*n +: 2]};
    end

`ifdef RAW10_ROWCNT_EN
    logic [15:0] row_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                byte_q[i] <= 8'h00;
            cnt         <= 3'd0;
            grp_cnt     <= '0;
            sof_pending <= 1'b1;
            fr_d        <= 1'b0;
            pix         <= '0;
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_err   <= 1'b0;
`ifdef RAW10_ROWCNT_EN
            row_cnt     <= 16'd0;
            row_idx     <= 16'd0;
`endif
        end else begin
            fr_d      <= fr_active;
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                frame_err   <= (cnt != 3'd0) || (grp_cnt != '0);
                cnt         <= 3'd0;
                grp_cnt     <= '0;
                sof_pending <= 1'b1;
`ifdef RAW10_ROWCNT_EN
                row_cnt     <= 16'd0;
                row_idx     <= 16'd0;
`endif
            end else if (accept) begin
                if (grp_done) begin
                    pix         <= grp_pix;
                    pix_valid   <= 1'b1;
                    pix_sof     <= sof_pending;
                    sof_pending <= 1'b0;
`ifdef RAW10_ROWCNT_EN
                    row_idx     <= row_cnt;
`endif
                    if (grp_cnt == GRP_LAST) begin
                        // End of line: a leftover byte is line padding.
                        pix_eol <= 1'b1;
                        grp_cnt <= '0;
                        cnt     <= 3'd0;
`ifdef RAW10_ROWCNT_EN
                        if (row_cnt != 16'hFFFF)
                            row_cnt <= row_cnt + 16'd1;
`endif
                    end else begin
                        grp_cnt   <= grp_cnt + GW'(1);
                        cnt       <= cnt_sum - 3'd5;
                        byte_q[0] <= ext[5];
                    end
                end else begin
                    cnt <= cnt_sum;
                    for (int i = 0; i < 4; i++)
                        byte_q[i] <= ext[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_raw10_unpacker.sv
// tb_raw10_unpacker: directed table, hand sequences and randomized traffic
// for raw10_unpacker, checked against a byte-queue reference model.
module tb_raw10_unpacker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i [2];
    logic [15:0] din_i   [2];
    logic        dv_i    [2];
    logic        fa_i    [2];
    logic [39:0] pix_o   [2];
    logic        pv_o    [2];
    logic        sof_o   [2];
    logic        eol_o   [2];
    logic        err_o   [2];
`ifdef RAW10_ROWCNT_EN
    logic [15:0] row_o   [2];
`endif

    // dut0: 2 groups per line, dut1: 1 group per line
    raw10_unpacker #(.LINE_PIXELS(8)) dut0 (
        .clk(clk), .reset(reset_i[0]), .din(din_i[0]),
        .din_valid(dv_i[0]), .fr_active(fa_i[0]),
        .pix(pix_o[0]), .pix_valid(pv_o[0]), .pix_sof(sof_o[0]),
        .pix_eol(eol_o[0]),
`ifdef RAW10_ROWCNT_EN
        .row_idx(row_o[0]),
`endif
        .frame_err(err_o[0])
    );

    raw10_unpacker #(.LINE_PIXELS(4)) dut1 (
        .clk(clk), .reset(reset_i[1]), .din(din_i[1]),
        .din_valid(dv_i[1]), .fr_active(fa_i[1]),
        .pix(pix_o[1]), .pix_valid(pv_o[1]), .pix_sof(sof_o[1]),
        .pix_eol(eol_o[1]),
`ifdef RAW10_ROWCNT_EN
        .row_idx(row_o[1]),
`endif
        .frame_err(err_o[1])
    );

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: payload bytes in a queue, groups popped 5 at a time.
    logic [7:0]  mq   [2][$];
    int          mgrp [2];
    bit          msof [2];
    bit          mfad [2];
    int          mrow [2];
    logic [39:0] e_pix[2];
    bit          e_pv [2];
    bit          e_sof[2];
    bit          e_eol[2];
    bit          e_err[2];
    logic [15:0] e_row[2];

    function automatic int grp_per_line(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [39:0] mk(logic [9:0] p0, logic [9:0] p1,
                                       logic [9:0] p2, logic [9:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic model_edge(int k);
        logic [7:0] b [5];
        if (reset_i[k]) begin
            mq[k].delete();
            mgrp[k] = 0; msof[k] = 1; mfad[k] = 0; mrow[k] = 0;
            e_pix[k] = '0; e_pv[k] = 0; e_sof[k] = 0;
            e_eol[k] = 0; e_err[k] = 0; e_row[k] = '0;
        end else begin
            e_pv[k] = 0; e_sof[k] = 0; e_eol[k] = 0; e_err[k] = 0;
            if (mfad[k] && !fa_i[k]) begin
                e_err[k] = (mq[k].size() != 0) || (mgrp[k] != 0);
                mq[k].delete();
                mgrp[k] = 0; msof[k] = 1; mrow[k] = 0; e_row[k] = '0;
            end else if (dv_i[k] && fa_i[k]) begin
                mq[k].push_back(din_i[k][7:0]);
                mq[k].push_back(din_i[k][15:8]);
                if (mq[k].size() >= 5) begin
                    for (int n = 0; n < 5; n++)
                        b[n] = mq[k].pop_front();
                    for (int n = 0; n < 4; n++)
                        e_pix[k][10*n +: 10] =
                            10'(b[n] * 4 + ((b[4] >> (2 * n)) % 4));
                    e_pv[k]  = 1;
                    e_sof[k] = msof[k];
                    msof[k]  = 0;
                    e_row[k] = 16'(mrow[k]);
                    if (mgrp[k] == grp_per_line(k) - 1) begin
                        e_eol[k] = 1;
                        mgrp[k]  = 0;
                        mq[k].delete();
                        if (mrow[k] < 65535)
                            mrow[k]++;
                    end else begin
                        mgrp[k]++;
                    end
                end
            end
            mfad[k] = fa_i[k];
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_model(int k);
        chk($sformatf("d%0d_pv", k),  64'(pv_o[k]),  64'(e_pv[k]));
        chk($sformatf("d%0d_pix", k), 64'(pix_o[k]), 64'(e_pix[k]));
        chk($sformatf("d%0d_sof", k), 64'(sof_o[k]), 64'(e_sof[k]));
        chk($sformatf("d%0d_eol", k), 64'(eol_o[k]), 64'(e_eol[k]));
        chk($sformatf("d%0d_err", k), 64'(err_o[k]), 64'(e_err[k]));
`ifdef RAW10_ROWCNT_EN
        chk($sformatf("d%0d_row", k), 64'(row_o[k]), 64'(e_row[k]));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cmp_model(0);
        cmp_model(1);
    endtask

    // Drive one DUT for a cycle; the other idles with fr_active held.
    task automatic drv(int k, logic [15:0] d, logic dv, logic fa,
                       logic rst);
        din_i[k]     = d;
        dv_i[k]      = dv;
        fa_i[k]      = fa;
        reset_i[k]   = rst;
        dv_i[1-k]    = 1'b0;
        reset_i[1-k] = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic [15:0] d;
        logic        dv;
        logic        fa;
        logic        pv;
        logic [39:0] px;
        logic        sof;
        logic        eol;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    int npv;
    int nerrp;
    int eolmask;
    bit curfa [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset_i[k] = 1'b1; din_i[k] = '0;
            dv_i[k] = 1'b0; fa_i[k] = 1'b0;
        end
        cyc();
        cyc();

        // Reset held 2 cycles with traffic present
        for (int i = 0; i < 2; i++) begin
            drv(0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
            chk("rst_pv",  64'(pv_o[0]),  64'd0);
            chk("rst_pix", 64'(pix_o[0]), 64'd0);
            chk("rst_flags", 64'({sof_o[0], eol_o[0], err_o[0]}), 64'd0);
        end

        // Single group, stray byte, streaming alignment, frame end
        tbl[0]  = '{16'h3412, 1, 1, 0, 40'h0, 0, 0, 0};
        tbl[1]  = '{16'h7856, 1, 1, 0, 40'h0, 0, 0, 0};
        tbl[2]  = '{16'h00E4, 1, 1, 1,
                    mk(10'h048, 10'h0D1, 10'h15A, 10'h1E3), 1, 0, 0};
        tbl[3]  = '{16'hBBAA, 1, 1, 0,
                    mk(10'h048, 10'h0D1, 10'h15A, 10'h1E3), 0, 0, 0};
        tbl[4]  = '{16'hDDCC, 1, 1, 1,
                    mk(10'h001, 10'h2AB, 10'h2ED, 10'h333), 0, 1, 0};
        tbl[5]  = '{16'h0100, 1, 1, 0,
                    mk(10'h001, 10'h2AB, 10'h2ED, 10'h333), 0, 0, 0};
        tbl[6]  = '{16'h0302, 1, 1, 0,
                    mk(10'h001, 10'h2AB, 10'h2ED, 10'h333), 0, 0, 0};
        tbl[7]  = '{16'h0504, 1, 1, 1,
                    mk(10'h000, 10'h005, 10'h008, 10'h00C), 0, 0, 0};
        tbl[8]  = '{16'h0706, 1, 1, 0,
                    mk(10'h000, 10'h005, 10'h008, 10'h00C), 0, 0, 0};
        tbl[9]  = '{16'h0908, 1, 1, 1,
                    mk(10'h015, 10'h01A, 10'h01C, 10'h020), 0, 1, 0};
        tbl[10] = '{16'h5555, 0, 1, 0,
                    mk(10'h015, 10'h01A, 10'h01C, 10'h020), 0, 0, 0};
        tbl[11] = '{16'h5555, 1, 0, 0,
                    mk(10'h015, 10'h01A, 10'h01C, 10'h020), 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            drv(0, tbl[i].d, tbl[i].dv, tbl[i].fa, 1'b0);
            chk($sformatf("tbl%0d_pv", i),  64'(pv_o[0]),  64'(tbl[i].pv));
            chk($sformatf("tbl%0d_pix", i), 64'(pix_o[0]), 64'(tbl[i].px));
            chk($sformatf("tbl%0d_sof", i), 64'(sof_o[0]), 64'(tbl[i].sof));
            chk($sformatf("tbl%0d_eol", i), 64'(eol_o[0]), 64'(tbl[i].eol));
            chk($sformatf("tbl%0d_err", i), 64'(err_o[0]), 64'(tbl[i].err));
        end

        // Line boundary: 3 lines of 10 bytes, 2 groups per line
        npv = 0;
        eolmask = 0;
        for (int w = 0; w < 15; w++) begin
            drv(0, {8'(2 * w + 17), 8'(2 * w + 16)}, 1'b1, 1'b1, 1'b0);
            if (pv_o[0] === 1'b1) begin
                npv++;
                if (eol_o[0] === 1'b1)
                    eolmask |= (1 << npv);
            end
        end
        chk("line_groups", 64'(npv), 64'd6);
        chk("line_eolpos", 64'(eolmask), 64'h54);
        drv(0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Odd-length lines with pad byte 0xAA
        drv(1, 16'h2211, 1'b1, 1'b1, 1'b0);
        drv(1, 16'h4433, 1'b1, 1'b1, 1'b0);
        drv(1, 16'hAA55, 1'b1, 1'b1, 1'b0);
        chk("odd_l1_pv", 64'(pv_o[1]), 64'd1);
        drv(1, 16'h7766, 1'b1, 1'b1, 1'b0);
        drv(1, 16'h9988, 1'b1, 1'b1, 1'b0);
        drv(1, 16'hAA00, 1'b1, 1'b1, 1'b0);
        chk("odd_l2_pv", 64'(pv_o[1]), 64'd1);
        chk("odd_l2_p0", 64'(pix_o[1][9:0]), 64'h198);
        drv(1, 16'h0, 1'b0, 1'b0, 1'b0);

        // Truncated frame then clean restart
        npv = 0;
        nerrp = 0;
        drv(1, 16'h0201, 1'b1, 1'b1, 1'b0);
        npv += int'(pv_o[1]); nerrp += int'(err_o[1]);
        drv(1, 16'h0403, 1'b1, 1'b1, 1'b0);
        npv += int'(pv_o[1]); nerrp += int'(err_o[1]);
        drv(1, 16'h0605, 1'b1, 1'b0, 1'b0);
        npv += int'(pv_o[1]); nerrp += int'(err_o[1]);
        drv(1, 16'h0807, 1'b1, 1'b0, 1'b0);
        npv += int'(pv_o[1]); nerrp += int'(err_o[1]);
        chk("trunc_err_pulses", 64'(nerrp), 64'd1);
        chk("trunc_no_pv", 64'(npv), 64'd0);
        drv(1, 16'h3412, 1'b1, 1'b1, 1'b0);
        drv(1, 16'h7856, 1'b1, 1'b1, 1'b0);
        drv(1, 16'h00E4, 1'b1, 1'b1, 1'b0);
        chk("restart_sof", 64'(sof_o[1]), 64'd1);
        chk("restart_pix", 64'(pix_o[1]),
            64'(mk(10'h048, 10'h0D1, 10'h15A, 10'h1E3)));
        drv(1, 16'h0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame drops the in-flight group
        drv(0, 16'h3412, 1'b1, 1'b1, 1'b0);
        drv(0, 16'h7856, 1'b1, 1'b1, 1'b0);
        drv(0, 16'h00E4, 1'b1, 1'b1, 1'b1);
        chk("midrst_pv", 64'(pv_o[0]), 64'd0);
        chk("midrst_pix", 64'(pix_o[0]), 64'd0);
        drv(0, 16'hBBAA, 1'b1, 1'b1, 1'b0);
        drv(0, 16'hDDCC, 1'b1, 1'b1, 1'b0);
        drv(0, 16'hFFEE, 1'b1, 1'b1, 1'b0);
        chk("midrst_new_sof", 64'(sof_o[0]), 64'd1);
        drv(0, 16'h0, 1'b0, 1'b0, 1'b0);
        drv(1, 16'h0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic on both instances
        curfa[0] = 0;
        curfa[1] = 0;
        for (int it = 0; it < 4000; it++) begin
            int  k;
            bit  rst;
            k = int'($urandom_range(0, 1));
            if (curfa[k]) begin
                if ($urandom_range(0, 59) == 0)
                    curfa[k] = 0;
            end else if ($urandom_range(0, 4) == 0) begin
                curfa[k] = 1;
            end
            rst = ($urandom_range(0, 299) == 0);
            drv(k, 16'($urandom), ($urandom_range(0, 3) != 0),
                curfa[k], rst);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerr);
        $finish;
    end

endmodule
